// File: rtl/id_usercode_register.sv
`default_nettype none
// ============================================================================
//  Module      : id_usercode_register
//  Description : JTAG identification data register serving both IDCODE and
//                USERCODE. Captures DEVICE_ID or the USERCODE holding
//                register into a DR_WIDTH-bit shift chain. It also tracks
//                the number of shifted bits, so that only an exact
//                DR_WIDTH-bit scan can commit a USERCODE write at Update-DR.
//  Ports       : tck, trst (sync active-low)       clock / reset
//                tdi / tdo                         serial data in / out
//                select_idcode, select_usercode    decoded instruction
//                captureDR, shiftDR, updateDR      TAP DR strobes
//                user_lock                         blocks USERCODE writes
//                usercode                          holding-register value
//                shift_count                       bits shifted since capture
//                update_error                      sticky rejected-write flag
//  Revision    : 1.0  initial release
// ============================================================================
module id_usercode_register #(
    parameter int                  DR_WIDTH          = 32,
    parameter logic [DR_WIDTH-1:0] DEVICE_ID         = 32'h0000_0001,
    parameter logic [DR_WIDTH-1:0] USERCODE_RESET    = 32'h0000_0000,
    parameter bit                  USERCODE_WRITABLE = 1'b1
) (
    input  logic                              tck,
    input  logic                              trst,
    input  logic                              tdi,
    output logic                              tdo,
    input  logic                              select_idcode,
    input  logic                              select_usercode,
    input  logic                              captureDR,
    input  logic                              shiftDR,
    input  logic                              updateDR,
    input  logic                              user_lock,
    output logic [DR_WIDTH-1:0]               usercode,
    output logic [$clog2(DR_WIDTH+1)-1:0]     shift_count,
    output logic                              update_error
);

    localparam int CW = $clog2(DR_WIDTH + 1);
    localparam logic [CW-1:0] c_full_count = CW'(DR_WIDTH);

    // IEEE 1149.1 requires the IDCODE LSB to be 1 to distinguish it from BYPASS.
    if (DEVICE_ID[0] != 1'b1) begin : g_idcode_lsb_check
        $error("id_usercode_register: DEVICE_ID bit 0 must be 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOADED   = 3'd1,
        ST_SHIFTING = 3'd2,
        ST_FULL     = 3'd3,
        ST_OVERRUN  = 3'd4
    } state_t;

    state_t                state_q,        state_d;
    logic [DR_WIDTH-1:0]   shift_reg_q,    shift_reg_d;
    logic [DR_WIDTH-1:0]   usercode_q,     usercode_d;
    logic [CW-1:0]         shift_count_q,  shift_count_d;
    logic                  update_error_q, update_error_d;

    logic                  w_sel;
    logic                  w_is_id;
    logic                  w_is_uc;
    logic [CW-1:0]         w_count_inc;
    logic                  w_write_ok;

    // IDCODE takes precedence when both instructions are reported active.
    assign w_sel       = select_idcode | select_usercode;
    assign w_is_id     = select_idcode;
    assign w_is_uc     = select_usercode & ~select_idcode;
    assign w_count_inc = shift_count_q + 1'b1;
    assign w_write_ok  = w_is_uc && USERCODE_WRITABLE &&
                         (state_q == ST_FULL) && !user_lock;

    always_comb begin
        state_d        = state_q;
        shift_reg_d    = shift_reg_q;
        usercode_d     = usercode_q;
        shift_count_d  = shift_count_q;
        update_error_d = update_error_q;

        if (w_sel) begin
            if (captureDR) begin
                shift_reg_d   = w_is_id ? DEVICE_ID : usercode_q;
                shift_count_d = '0;
                state_d       = ST_LOADED;
            end else if (shiftDR) begin
                shift_reg_d = {tdi, shift_reg_q[DR_WIDTH-1:1]};
                case (state_q)
                    ST_LOADED, ST_SHIFTING: begin
                        shift_count_d = w_count_inc;
                        state_d       = (w_count_inc == c_full_count) ? ST_FULL : ST_SHIFTING;
                    end
                    ST_FULL, ST_OVERRUN: begin
                        // Count saturates; an over-long scan can never look exact again.
                        shift_count_d = c_full_count;
                        state_d       = ST_OVERRUN;
                    end
                    default: begin
                        // Shifting without a prior capture moves data but is not counted.
                    end
                endcase
            end else if (updateDR) begin
                if (w_write_ok) begin
                    usercode_d = shift_reg_q;
                end else if (w_is_uc) begin
                    update_error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge tck) begin
        if (!trst) begin
            state_q        <= ST_IDLE;
            shift_reg_q    <= DEVICE_ID;
            usercode_q     <= USERCODE_RESET;
            shift_count_q  <= '0;
            update_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_reg_q    <= shift_reg_d;
            usercode_q     <= usercode_d;
            shift_count_q  <= shift_count_d;
            update_error_q <= update_error_d;
        end
    end

    assign tdo          = shift_reg_q[0];
    assign usercode     = usercode_q;
    assign shift_count  = shift_count_q;
    assign update_error = update_error_q;

endmodule
`default_nettype wire

// File: tb/tb_id_usercode_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_usercode_register
//  Description : Directed self-checking bench for id_usercode_register.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_usercode_register;

    localparam int          DR_WIDTH = 32;
    localparam logic [31:0] C_DEV_ID = 32'h4BA0_0477;
    localparam logic [31:0] C_UC_RST = 32'h0000_5A5A;

    logic        tck = 1'b0;
    logic        trst = 1'b0;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        select_idcode = 1'b0;
    logic        select_usercode = 1'b0;
    logic        captureDR = 1'b0;
    logic        shiftDR = 1'b0;
    logic        updateDR = 1'b0;
    logic        user_lock = 1'b0;
    logic [31:0] usercode;
    logic [5:0]  shift_count;
    logic        update_error;

    int n_vec = 0;
    int n_err = 0;

    id_usercode_register #(
        .DR_WIDTH          (DR_WIDTH),
        .DEVICE_ID         (C_DEV_ID),
        .USERCODE_RESET    (C_UC_RST),
        .USERCODE_WRITABLE (1'b1)
    ) u_dut (
        .tck             (tck),
        .trst            (trst),
        .tdi             (tdi),
        .tdo             (tdo),
        .select_idcode   (select_idcode),
        .select_usercode (select_usercode),
        .captureDR       (captureDR),
        .shiftDR         (shiftDR),
        .updateDR        (updateDR),
        .user_lock       (user_lock),
        .usercode        (usercode),
        .shift_count     (shift_count),
        .update_error    (update_error)
    );

    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus changes 1 time unit after the rising edge.
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic do_reset();
        trst = 1'b0;
        tick();
        trst = 1'b1;
    endtask

    task automatic do_capture();
        captureDR = 1'b1;
        tick();
        captureDR = 1'b0;
    endtask

    task automatic do_update();
        updateDR = 1'b1;
        tick();
        updateDR = 1'b0;
    endtask

    // Shifts n bits of din LSB-first; dout gathers tdo seen before each shift.
    task automatic scan(input logic [31:0] din, input int n, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            if (i < 32) begin
                dout[i] = tdo;
                tdi     = din[i];
            end else begin
                tdi = 1'b0;
            end
            shiftDR = 1'b1;
            tick();
        end
        shiftDR = 1'b0;
        tdi     = 1'b0;
    endtask

    initial begin
        logic [31:0] got;

        // T1: reset state and IDCODE readout
        do_reset();
        check("rst_tdo", tdo, 1'b1);
        check("rst_count", shift_count, 6'd0);
        check("rst_usercode", usercode, C_UC_RST);
        check("rst_err", update_error, 1'b0);

        select_idcode = 1'b1;
        do_capture();
        check("id_cap_bit0", tdo, 1'b1);
        check("id_cap_count", shift_count, 6'd0);
        scan(32'h0, 32, got);
        check("id_stream", got, C_DEV_ID);
        check("id_full_count", shift_count, 6'd32);
        do_update();
        check("id_update_no_err", update_error, 1'b0);
        check("id_update_no_write", usercode, C_UC_RST);
        select_idcode = 1'b0;

        // No select: strobes are ignored
        do_capture();
        shiftDR = 1'b1;
        tick();
        shiftDR = 1'b0;
        check("nosel_count_hold", shift_count, 6'd32);

        // T2: USERCODE write and readback
        select_usercode = 1'b1;
        do_capture();
        scan(32'hCAFE_F00D, 32, got);
        check("uc_cap_stream_reset", got, C_UC_RST);
        do_update();
        check("uc_write", usercode, 32'hCAFE_F00D);
        check("uc_write_no_err", update_error, 1'b0);
        do_capture();
        scan(32'h0, 32, got);
        check("uc_readback", got, 32'hCAFE_F00D);

        // T5: capture beats shift in the same cycle
        captureDR = 1'b1;
        shiftDR   = 1'b1;
        tick();
        captureDR = 1'b0;
        shiftDR   = 1'b0;
        check("cap_shift_count", shift_count, 6'd0);
        check("cap_shift_tdo", tdo, 1'b1);
        shiftDR = 1'b1;
        tick();
        shiftDR = 1'b0;
        check("cap_shift_bit1", tdo, 1'b0);
        check("cap_shift_count1", shift_count, 6'd1);

        // Both selects: IDCODE wins
        select_idcode = 1'b1;
        do_capture();
        scan(32'h0, 32, got);
        check("both_sel_stream", got, C_DEV_ID);
        select_idcode = 1'b0;

        // T3: short scan rejected
        do_capture();
        scan(32'hFFFF_FFFF, 31, got);
        check("short_count", shift_count, 6'd31);
        do_update();
        check("short_no_write", usercode, 32'hCAFE_F00D);
        check("short_err", update_error, 1'b1);

        // T3: over-long scan rejected
        do_reset();
        check("rst2_err", update_error, 1'b0);
        do_capture();
        scan(32'h0F0F_0F0F, 33, got);
        check("long_count_sat", shift_count, 6'd32);
        do_update();
        check("long_no_write", usercode, C_UC_RST);
        check("long_err", update_error, 1'b1);

        // T4: lock blocks an exact write
        do_reset();
        user_lock = 1'b1;
        do_capture();
        scan(32'h1234_5678, 32, got);
        do_update();
        check("lock_no_write", usercode, C_UC_RST);
        check("lock_err", update_error, 1'b1);
        user_lock = 1'b0;

        // T6: reset in the middle of a scan
        do_reset();
        do_capture();
        scan(32'h0F0F_1234, 32, got);
        do_update();
        check("pre6_write", usercode, 32'h0F0F_1234);
        select_usercode = 1'b0;
        select_idcode   = 1'b1;
        do_capture();
        scan(32'h0, 10, got);
        check("pre6_count", shift_count, 6'd10);
        trst    = 1'b0;
        shiftDR = 1'b1;
        tick();
        shiftDR = 1'b0;
        trst    = 1'b1;
        check("mid_rst_tdo", tdo, 1'b1);
        check("mid_rst_count", shift_count, 6'd0);
        check("mid_rst_usercode", usercode, C_UC_RST);
        // IDLE: a shift is not counted and update under USERCODE is rejected
        select_idcode   = 1'b0;
        select_usercode = 1'b1;
        shiftDR = 1'b1;
        tick();
        shiftDR = 1'b0;
        check("idle_shift_nocount", shift_count, 6'd0);
        check("idle_shift_tdo", tdo, C_DEV_ID[1]);
        do_update();
        check("idle_update_err", update_error, 1'b1);
        check("idle_update_nowrite", usercode, C_UC_RST);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
